// File: rtl/cacheline_adapter.sv
// Bridges a cache-line port to a beat-oriented memory burst port: read beats are assembled into a line, write lines are split into beats.
// Optional watchdog abort with err, enabled by defining CACHELINE_ADAPTER_TIMEOUT_EN.
module cacheline_adapter #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pmem_address,
    input  logic               pmem_read,
    input  logic               pmem_write,
    input  logic [s_line-1:0]  pmem_wdata,
    output logic [s_line-1:0]  pmem_rdata,
    output logic               pmem_resp,
    output logic [31:0]        burst_address,
    output logic               burst_read,
    output logic               burst_write,
    input  logic [s_burst-1:0] burst_rdata,
    output logic [s_burst-1:0] burst_wdata,
    input  logic               burst_resp,
    output logic               err
);
    localparam int BEATS = s_line / s_burst;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(s_line / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [s_line-1:0]  wline_q, wline_d;
    logic [s_line-1:0]  rline_q, rline_d;
    logic [s_burst-1:0] wbeat [BEATS];
    logic               unused_addr_bits;

`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
    logic [7:0]         wd_q, wd_d;
    logic               err_q, err_d;
`endif

    // Byte offset within the line is dropped; memory always sees line-aligned addresses.
    assign unused_addr_bits = ^pmem_address[OFF_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign wbeat[gi] = wline_q[gi*s_burst +: s_burst];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pmem_write || pmem_read) begin
                    state_d = pmem_write ? WRITE : READ;
                    addr_d  = {pmem_address[31:OFF_W], OFF_W'(0)};
                    cnt_d   = '0;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
                    wd_d    = '0;
`endif
                    if (pmem_write)
                        wline_d = pmem_wdata;
                end
            end
            READ, WRITE: begin
                if (burst_resp) begin
                    for (int i = 0; i < BEATS; i++)
                        if (state_q == READ && cnt_q == CNT_W'(i))
                            rline_d[i*s_burst +: s_burst] = burst_rdata;
                    cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT)
                        state_d = DONE;
                end
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
                // A beat arriving on the final watchdog cycle still wins over the abort.
                if (burst_resp)
                    wd_d = '0;
                else if (wd_q == 8'hFF) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else
                    wd_d = wd_q + 8'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign pmem_rdata    = rline_q;
    assign pmem_resp     = (state_q == DONE);
    assign burst_address = addr_q;
    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign burst_wdata   = (state_q == WRITE) ? wbeat[cnt_q] : '0;
`ifdef CACHELINE_ADAPTER_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter s_line, default 256: cache line width in bits.
REQ-002 SHALL have parameter s_burst, default 64: memory beat width in bits; beats per line = s_line/s_burst (4 at defaults).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port pmem_address  input  32  line address from cache.
REQ-006 SHALL have port pmem_read  input  1  cache line read request.
REQ-007 SHALL have port pmem_write  input  1  cache line write request.
REQ-008 SHALL have port pmem_wdata  input  s_line  line to write back.
REQ-009 SHALL have port pmem_rdata  output  s_line  assembled fill line.
REQ-010 SHALL have port pmem_resp  output  1  one-cycle completion pulse to cache.
REQ-011 SHALL have port burst_address  output  32  line-aligned memory address.
REQ-012 SHALL have port burst_read  output  1  memory burst read strobe.
REQ-013 SHALL have port burst_write  output  1  memory burst write strobe.
REQ-014 SHALL have port burst_rdata  input  s_burst  beat from memory.
REQ-015 SHALL have port burst_wdata  output  s_burst  beat to memory.
REQ-016 SHALL have port burst_resp  input  1  beat transferred this cycle.
REQ-017 SHALL have port err  output  1  timeout abort flag (see Configuration).

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-019 SHALL, in IDLE, accept pmem_write (priority) or else pmem_read on a rising edge; requests in other states ignored.
REQ-020 SHALL on accept register burst_address = {pmem_address[31:5], 5'b0}, latch pmem_wdata on writes, clear 2-bit beat counter.
REQ-021 SHALL assert burst_read in READ and burst_write in WRITE, combinationally from state, beginning the cycle after accept.
REQ-022 SHALL transfer beat k = line bits [64k+63:64k] (beat 0 least significant) on each cycle burst_resp is high; gaps between beats allowed.
REQ-023 SHALL in READ write burst_rdata into beat slot k of pmem_rdata on each burst_resp cycle.
REQ-024 SHALL in WRITE drive burst_wdata = latched line beat k, where k is the current counter value.
REQ-025 SHALL on the burst_resp cycle with k = 3 deassert strobes next cycle and enter DONE; counter wraps 3->0.
REQ-026 SHALL assert pmem_resp for exactly one cycle in DONE, then return to IDLE; new request accepted no earlier than the cycle after DONE.
REQ-027 SHALL hold pmem_rdata stable from DONE until the next read accept.
REQ-028 SHALL ignore burst_resp in IDLE and DONE.
REQ-029 SHALL never assert burst_read and burst_write simultaneously.

Reset
REQ-030 SHALL on rst force IDLE, beat counter 0, pmem_rdata 0, pmem_resp 0, burst_read 0, burst_write 0, burst_address 0, burst_wdata 0, err 0.
REQ-031 SHALL on rst mid-burst discard the partial line and issue no pmem_resp.

Configuration
REQ-032 SHALL with CACHELINE_ADAPTER_TIMEOUT_EN defined include an 8-bit watchdog, cleared on accept and on each burst_resp, incremented each READ/WRITE cycle.
REQ-033 SHALL with CACHELINE_ADAPTER_TIMEOUT_EN defined, on watchdog reaching 255, abort to DONE, pulse pmem_resp with err high for that same cycle.
REQ-034 SHALL without CACHELINE_ADAPTER_TIMEOUT_EN tie err to 0 and wait indefinitely for burst_resp.

Verification
REQ-035 SHALL cover read: pmem_read, pmem_address 0x1234_567F; beats 0x11..11,0x22..22,0x33..33,0x44..44 back-to-back -> burst_address 0x1234_5660, pmem_rdata = {0x44..,0x33..,0x22..,0x11..}, single pmem_resp.
REQ-036 SHALL cover write: pmem_wdata = {D3,D2,D1,D0}, burst_resp with 2-cycle gaps -> burst_wdata D0,D1,D2,D3 in order, burst_write dropped after D3, one pmem_resp.
REQ-037 SHALL cover pmem_read and pmem_write both high in IDLE -> WRITE performed, burst_read never asserted.
REQ-038 SHALL cover rst asserted after beat 1 of a read -> all outputs 0 immediately, no pmem_resp, next read completes normally.
REQ-039 SHALL cover (TIMEOUT_EN) read with no burst_resp -> pmem_resp and err high together 256 cycles after strobe assertion; (no macro) no pmem_resp, err stays 0.
